// File: rtl/inst_buffer_pkg.sv
// Shared types and helpers for the two-wide decode-to-issue instruction queue.
package inst_buffer_pkg;

  localparam int unsigned IB_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } inst_t;

  // Population count of a 2-bit valid/issue mask.
  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/inst_buffer_mem.sv
// Instruction queue storage: two write ports at waddr/waddr+1, two combinational
// read ports at raddr/raddr+1; the +1 wraps because DEPTH is a power of two.
module inst_buffer_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [1:0]       we,
  input  logic [PTR_W-1:0] waddr,
  input  inst_t [1:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output inst_t [1:0]      rdata
);

  inst_t mem [DEPTH];

  logic [PTR_W-1:0] waddr1;
  logic [PTR_W-1:0] raddr1;

  assign waddr1 = waddr + PTR_W'(1);
  assign raddr1 = raddr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr]  <= wdata[0];
    if (we[1]) mem[waddr1] <= wdata[1];
  end

  assign rdata[0] = mem[raddr];
  assign rdata[1] = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// Two-wide in-order instruction queue between decode and issue; pointer and
// occupancy control, with storage in inst_buffer_mem.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  inst_t [1:0] inst_i,
  input  logic [1:0]  w_valid_i,
  output logic        w_ready_o,
  output inst_t [1:0] inst_o,
  output logic [1:0]  valid_o,
  input  logic [1:0]  is_i
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic             push_en;
  logic [1:0]       npush;
  logic [1:0]       npop;
  logic [1:0]       we;

  // Capacity is judged on the pre-pop count, so a slot freed this cycle is not reused.
  assign w_ready_o = (count <= (PTR_W+1)'(DEPTH - 2));

  always_comb begin
    push_en = w_ready_o && (|w_valid_i) && !flush_i;
    npush   = push_en ? popcnt2(w_valid_i) : 2'd0;
    npop    = flush_i ? 2'd0 : popcnt2(is_i);
    we      = push_en ? w_valid_i : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(npop);
      wr_ptr <= wr_ptr + PTR_W'(npush);
      count  <= count + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
    end
  end

  always_comb begin
    if (count == '0)
      valid_o = 2'b00;
    else if (count == (PTR_W+1)'(1))
      valid_o = 2'b01;
    else
      valid_o = 2'b11;
  end

  inst_buffer_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (inst_i),
    .raddr (rd_ptr),
    .rdata (inst_o)
  );

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  inst_t [1:0] inst_i;
  logic [1:0]  w_valid_i;
  logic        w_ready_o;
  inst_t [1:0] inst_o;
  logic [1:0]  valid_o;
  logic [1:0]  is_i;

  inst_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .inst_i    (inst_i),
    .w_valid_i (w_valid_i),
    .w_ready_o (w_ready_o),
    .inst_o    (inst_o),
    .valid_o   (valid_o),
    .is_i      (is_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  bit          started  = 1'b0;
  inst_t       q[$];
  logic [31:0] next_pc  = 32'h0000_1000;

  function automatic inst_t mk(input logic [31:0] pc);
    inst_t t;
    t.pc    = pc;
    t.instr = ~pc;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries, updated at each clock edge.
  always @(posedge clk) begin
    int sz;
    int np;
    bit ready;
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (started) begin
      assert (w_valid_i != 2'b10) else $error("illegal w_valid_i");
      assert (is_i != 2'b10) else $error("illegal is_i");
      assert ((is_i & ~valid_o) == 2'b00) else $error("is_i not subset of valid_o");
      if (flush_i) q.delete();
      else begin
        sz    = q.size();
        ready = (int'(DEPTH) - sz) >= 2;
        np    = int'(is_i[0]) + int'(is_i[1]);
        for (int k = 0; k < np; k++) if (q.size() > 0) void'(q.pop_front());
        if (ready && w_valid_i[0]) q.push_back(inst_i[0]);
        if (ready && w_valid_i[1]) q.push_back(inst_i[1]);
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    logic [1:0] exp_v;
    if (started) begin
      sz    = q.size();
      exp_v = (sz == 0) ? 2'b00 : (sz == 1) ? 2'b01 : 2'b11;
      check("valid_o", 64'(valid_o), 64'(exp_v));
      check("w_ready_o", 64'(w_ready_o), 64'((int'(DEPTH) - sz) >= 2));
      if (sz >= 1) check("inst_o0", inst_o[0], q[0]);
      if (sz >= 2) check("inst_o1", inst_o[1], q[1]);
    end
  end

  task automatic drive(input logic [1:0] w, input logic [1:0] iss, input logic fl);
    inst_i[0] = mk(next_pc);
    inst_i[1] = mk(next_pc + 32'd4);
    next_pc   = next_pc + 32'd8;
    w_valid_i = w;
    is_i      = iss;
    flush_i   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    rst       = 1'b1;
    flush_i   = 1'b0;
    w_valid_i = 2'b00;
    is_i      = 2'b00;
    inst_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(valid_o), 64'(2'b00));
    check("rst_ready", 64'(w_ready_o), 64'(1'b1));

    // Fill: four two-wide writes reach DEPTH, the rest are dropped.
    repeat (4) drive(2'b11, 2'b00, 1'b0);
    check("fill_ready_lo", 64'(w_ready_o), 64'(1'b0));
    repeat (2) drive(2'b11, 2'b00, 1'b0);
    check("fill_valid", 64'(valid_o), 64'(2'b11));
    check("fill_head_pc", 64'(inst_o[0].pc), 64'(32'h0000_1000));
    check("fill_head1_pc", 64'(inst_o[1].pc), 64'(32'h0000_1004));

    // Single-wide drain of three entries.
    drive(2'b00, 2'b00, 1'b1);
    check("flush1_valid", 64'(valid_o), 64'(2'b00));
    pc_a = next_pc;
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    check("drain_v0", 64'(valid_o), 64'(2'b11));
    drive(2'b00, 2'b01, 1'b0);
    check("drain_v1", 64'(valid_o), 64'(2'b11));
    check("drain_head", 64'(inst_o[0].pc), 64'(pc_a + 32'd4));
    drive(2'b00, 2'b01, 1'b0);
    check("drain_v2", 64'(valid_o), 64'(2'b01));
    check("drain_last", 64'(inst_o[0].pc), 64'(pc_a + 32'd8));
    drive(2'b00, 2'b01, 1'b0);
    check("drain_v3", 64'(valid_o), 64'(2'b00));

    // Steady state at four entries with simultaneous push/pop across the wrap.
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    repeat (10) drive(2'b11, 2'b11, 1'b0);
    check("steady_valid", 64'(valid_o), 64'(2'b11));
    check("steady_ready", 64'(w_ready_o), 64'(1'b1));

    // Flush with traffic at five entries.
    drive(2'b01, 2'b00, 1'b0);
    drive(2'b11, 2'b01, 1'b1);
    check("flush2_valid", 64'(valid_o), 64'(2'b00));
    pc_b = next_pc;
    drive(2'b01, 2'b00, 1'b0);
    check("flush2_mem0", 64'(dut.u_mem.mem[0].pc), 64'(pc_b));
    check("flush2_head", 64'(inst_o[0].pc), 64'(pc_b));
    check("flush2_v", 64'(valid_o), 64'(2'b01));

    // Near-full: seven entries refuse even a single write.
    repeat (3) drive(2'b11, 2'b00, 1'b0);
    check("nf_ready_lo", 64'(w_ready_o), 64'(1'b0));
    drive(2'b01, 2'b11, 1'b0);
    check("nf_ready_hi", 64'(w_ready_o), 64'(1'b1));
    drive(2'b01, 2'b00, 1'b0);
    check("nf_after_write", 64'(w_ready_o), 64'(1'b1));
    drive(2'b00, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Two-wide instruction queue between decode and the issue stage.
- Accepts up to two decoded inst_t per cycle from decode and presents the two oldest entries to issue as inst_o/valid_o.
- Issue returns an in-order consumption mask (is_i); the queue pops that many entries the same cycle.
- A flush discards all contents on redirect or exception.

Parameters:
- DEPTH, 8, number of inst_t entries; must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), width of the read and write pointers; count is PTR_W+1 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  discard all entries; highest priority
- inst_i  in  inst_t[1:0]  decoded instructions; slot 0 is older
- w_valid_i  in  2  write mask: 2'b00, 2'b01 or 2'b11
- w_ready_o  out  1  queue can take a two-wide write this cycle
- inst_o  out  inst_t[1:0]  head entries; slot 0 is oldest
- valid_o  out  2  head valid mask: 2'b00, 2'b01 or 2'b11
- is_i  in  2  issued mask from issue: 2'b00, 2'b01 or 2'b11; must be a subset of valid_o

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State: storage array mem[DEPTH], rd_ptr and wr_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (rst=1 at a clk edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - valid_o=2'b00, w_ready_o=1.
  - inst_o contents don't-care.
- w_ready_o = (DEPTH - count) >= 2. It is combinational from registered count and does not depend on is_i.
- Push:
  - Occurs when w_ready_o && |w_valid_i.
  - npush = w_valid_i[0] + w_valid_i[1].
  - inst_i[0] is written to mem[wr_ptr]; if npush=2, inst_i[1] is written to mem[wr_ptr+1].
  - wr_ptr += npush, modulo DEPTH.
  - w_valid_i while w_ready_o=0 is dropped; decode must hold its inputs.
- Pop: npop = is_i[0] + is_i[1]; rd_ptr += npop; the entries are consumed in the same cycle.
- Count update: count_next = count + npush_eff - npop.
  - Push and pop in the same cycle are both honoured.
  - Push capacity is judged against the pre-pop count, with no same-cycle slot reuse.
- Head outputs (combinational from registered state):
  - inst_o[0] = mem[rd_ptr]; inst_o[1] = mem[rd_ptr+1], with wrap.
  - valid_o = 2'b00 if count=0, 2'b01 if count=1, 2'b11 if count>=2.
- Latency: an entry written at edge N is visible at the head after edge N (valid_o in cycle N+1) when the queue was empty. There is no decode-to-issue bypass.
- Flush:
  - flush_i=1 at an edge gives rd_ptr=wr_ptr=0, count=0.
  - The same-cycle push and pop are ignored.
  - valid_o=2'b00 in the next cycle.
  - rst has priority over flush_i.
- Wrap-around: pointers roll from DEPTH-1 to 0. A two-wide push or pop straddling the wrap must address mem[DEPTH-1] and mem[0].
- Illegal inputs:
  - w_valid_i=2'b10 or is_i=2'b10.
  - is_i with a bit set where valid_o is clear.
  - The bench asserts on these; RTL behaviour is undefined.
- Full boundary: count=DEPTH-1 gives w_ready_o=0, even for a single write. This keeps the handshake simple.
- Empty boundary: count=0 gives valid_o=2'b00. Pop is then illegal.

Decomposition:
- inst_t already exists in the shared pipeline package; the queue adds no new fields.
- Add to the package:
  - a localparam for the default queue depth;
  - a function popcnt2(logic[1:0]) used for both npush and npop.
- Sub-module inst_buffer_mem: a DEPTH x inst_t register array with two write ports and two combinational read ports, addressed by pointers plus 0/1 with wrap.
- Pointer and count control stay in inst_buffer.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> valid_o=2'b00, w_ready_o=1, count=0.
- Fill: six cycles of w_valid_i=2'b11 with is_i=2'b00 on DEPTH=8 -> writes accepted on the first 4 cycles; w_ready_o=0 from cycle 5 on; valid_o=2'b11; inst_o[0] equals the first-written pc.
- Single-wide drain: fill 3 entries, then is_i=2'b01 for 3 cycles -> valid_o goes 2'b11, 2'b11, 2'b01, 2'b00; program order is preserved.
- Simultaneous push/pop at steady state:
  - count=4; w_valid_i=2'b11 and is_i=2'b11 for 10 cycles -> count stays 4.
  - Pointers wrap at least twice.
  - Every inst_o sequence matches the push order across the wrap at index 7->0.
- Flush with traffic: count=5; flush_i=1 with w_valid_i=2'b11 and is_i=2'b01 -> next cycle count=0, valid_o=2'b00; the next push lands at mem[0].
- Near-full single write: count=7, w_valid_i=2'b01 -> w_ready_o=0, no write; after is_i=2'b11 the count becomes 5, w_ready_o=1, and the write is accepted.
